// File: rtl/wifire_frame_ring.sv
// wifire_frame_ring: parses 802.15.4 PHY frames from the receiver byte stream into a ring of slots drained over the read port.
// Optional CRC-16/ITU-T FCS check is enabled by defining WIFIRE_RING_FCS_CHECK_EN.
module wifire_frame_ring #(
  parameter int BASE = 16,
  parameter int SLOT_AW = 2,
  parameter int WORD_AW = 6,
  parameter int DROP_W = 16
) (
  input  logic                       dsp_clk,
  input  logic                       reset,
  input  logic                       set_stb,
  input  logic [7:0]                 set_addr,
  input  logic [31:0]                set_data,
  input  logic [7:0]                 rcv_byte_i,
  input  logic                       rcv_byte_stb_i,
  input  logic                       rcv_sfd_i,
  input  logic [31:0]                rcv_power_level_i,
  input  logic                       rd_stb_i,
  input  logic [SLOT_AW+WORD_AW:0]   rd_adr_i,
  output logic [31:0]                rd_dat_o,
  output logic                       rd_ack_o,
  output logic                       irq_frame_o,
  output logic                       irq_drop_o
);
  localparam int NS = 1 << SLOT_AW;
  localparam int CAP = ((1 << WORD_AW) - 2) * 4;
  typedef enum logic [1:0] {IDLE, LEN, BODY, COMMIT} state_t;
  state_t state_q, state_d;
  logic [SLOT_AW-1:0] head_q, wr_q, rslot;
  logic [SLOT_AW:0] count_q;
  logic [DROP_W-1:0] drop_q;
  logic en_q, drop_pulse_q, trunc_q, rd_ack_q;
  logic [31:0] pwr_q, word_q, rd_dat_q, rd_d;
  logic [6:0] len_q, idx_q;
  logic [7:0] stored;
  logic [WORD_AW-1:0] rword, wslot, pidx;
  logic [31:0] dmem [NS << WORD_AW];
  logic [31:0] smem [NS];
  logic [31:0] pmem [NS];
  logic flush, set_en, rel, clr_drop, full, len_ok, sfd_go, drop_ev, body_byte, keep, word_we, commit, fcs_ok;
  logic unused_set_bits;
  assign unused_set_bits = ^set_data[31:1];
  assign flush = set_stb && set_addr == 8'(BASE);
  assign set_en = set_stb && set_addr == 8'(BASE + 1);
  assign rel = set_stb && set_addr == 8'(BASE + 2) && count_q != '0;
  assign clr_drop = set_stb && set_addr == 8'(BASE + 3);
  assign full = count_q == (SLOT_AW+1)'(NS);
  assign len_ok = rcv_byte_i != 8'd0 && !rcv_byte_i[7];
  always_ff @(posedge dsp_clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rcv_sfd_i && en_q && !full) state_d = LEN;
      LEN: if (!rcv_sfd_i && rcv_byte_stb_i) state_d = len_ok ? BODY : IDLE;
      BODY: if (rcv_sfd_i) state_d = LEN;
            else if (rcv_byte_stb_i && idx_q + 7'd1 == len_q) state_d = COMMIT;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end
  always_comb begin
    sfd_go = rcv_sfd_i && (state_q == IDLE ? en_q && !full : state_q != COMMIT);
    drop_ev = !flush && ((state_q == IDLE && rcv_sfd_i && en_q && full) ||
                         (state_q == LEN && !rcv_sfd_i && rcv_byte_stb_i && !len_ok));
    body_byte = state_q == BODY && !rcv_sfd_i && rcv_byte_stb_i;
    keep = body_byte && int'(idx_q) < CAP;
    word_we = keep && idx_q[1:0] == 2'b11;
    commit = state_q == COMMIT && !flush;
    stored = int'(len_q) > CAP ? 8'(CAP) : {1'b0, len_q};
    wslot = WORD_AW'(int'(idx_q[6:2]) + 2);
    pidx = WORD_AW'(int'(stored[7:2]) + 2);
  end
  always_ff @(posedge dsp_clk) begin
    if (reset) begin
      head_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      drop_q <= '0;
      en_q <= 1'b0;
      drop_pulse_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_dat_q <= '0;
    end else begin
      drop_pulse_q <= drop_ev;
      rd_ack_q <= rd_stb_i;
      rd_dat_q <= rd_stb_i ? rd_d : rd_dat_q;
      if (set_en) en_q <= set_data[0];
      if (clr_drop) drop_q <= '0;
      else if (drop_ev && !(&drop_q)) drop_q <= drop_q + DROP_W'(1);
      if (flush) begin
        head_q <= '0;
        wr_q <= '0;
        count_q <= '0;
      end else begin
        if (commit) wr_q <= wr_q + SLOT_AW'(1);
        if (rel) head_q <= head_q + SLOT_AW'(1);
        count_q <= count_q + (SLOT_AW+1)'(commit) - (SLOT_AW+1)'(rel);
      end
    end
  end
  // Frame datapath needs no reset: every field is reinitialised at SFD.
  always_ff @(posedge dsp_clk) begin
    if (sfd_go) begin
      pwr_q <= rcv_power_level_i;
      idx_q <= '0;
      word_q <= '0;
      trunc_q <= 1'b0;
    end
    if (state_q == LEN && rcv_byte_stb_i && !rcv_sfd_i) len_q <= rcv_byte_i[6:0];
    if (body_byte) begin
      idx_q <= idx_q + 7'd1;
      if (!keep) trunc_q <= 1'b1;
      else word_q <= word_we ? '0 : word_q | (32'(rcv_byte_i) << {idx_q[1:0], 3'b000});
    end
    if (word_we) dmem[{wr_q, wslot}] <= {rcv_byte_i, word_q[23:0]};
    if (commit) begin
      if (stored[1:0] != 2'b00) dmem[{wr_q, pidx}] <= word_q;
      smem[wr_q] <= {14'd0, fcs_ok, trunc_q, stored, 1'b0, len_q};
      pmem[wr_q] <= pwr_q;
    end
  end
`ifdef WIFIRE_RING_FCS_CHECK_EN
  logic [15:0] crc_q, crc_d;
  always_comb begin
    crc_d = crc_q ^ {8'd0, rcv_byte_i};
    for (int i = 0; i < 8; i++) crc_d = crc_d[0] ? (crc_d >> 1) ^ 16'h8408 : crc_d >> 1;
  end
  always_ff @(posedge dsp_clk) crc_q <= sfd_go ? '0 : body_byte ? crc_d : crc_q;
  assign fcs_ok = crc_q == 16'd0 && !trunc_q;
`else
  assign fcs_ok = 1'b0;
`endif
  assign rslot = head_q + rd_adr_i[SLOT_AW+WORD_AW-1:WORD_AW];
  assign rword = rd_adr_i[WORD_AW-1:0];
  // Slot addresses are head-relative so software always reads the oldest frame at offset 0.
  always_comb
    rd_d = rd_adr_i[SLOT_AW+WORD_AW] ? (rword == '0 ? 32'({count_q, head_q, wr_q, drop_q}) : '0) :
           rword == '0 ? smem[rslot] : rword == WORD_AW'(1) ? pmem[rslot] : dmem[{rslot, rword}];
  assign rd_dat_o = rd_dat_q;
  assign rd_ack_o = rd_ack_q;
  assign irq_frame_o = count_q != '0;
  assign irq_drop_o = drop_pulse_q;
endmodule

// File: tb/tb_wifire_frame_ring.sv
// tb_wifire_frame_ring: randomized directed bench for wifire_frame_ring against a queue-based frame model.
// Built with WORD_AW=3 so the 24-byte slot capacity and truncation are reachable.
module tb_wifire_frame_ring;
  localparam int BASE = 16, SLOT_AW = 2, WORD_AW = 3, DROP_W = 16;
  localparam int NS = 4, CAP = 24;
  logic dsp_clk, reset, set_stb;
  logic [7:0] set_addr;
  logic [31:0] set_data;
  logic [7:0] rcv_byte_i;
  logic rcv_byte_stb_i, rcv_sfd_i;
  logic [31:0] rcv_power_level_i;
  logic rd_stb_i;
  logic [SLOT_AW+WORD_AW:0] rd_adr_i;
  logic [31:0] rd_dat_o;
  logic rd_ack_o, irq_frame_o, irq_drop_o;
  wifire_frame_ring #(.BASE(BASE), .SLOT_AW(SLOT_AW), .WORD_AW(WORD_AW), .DROP_W(DROP_W)) dut (
    .dsp_clk(dsp_clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
    .rcv_byte_i(rcv_byte_i), .rcv_byte_stb_i(rcv_byte_stb_i), .rcv_sfd_i(rcv_sfd_i),
    .rcv_power_level_i(rcv_power_level_i), .rd_stb_i(rd_stb_i), .rd_adr_i(rd_adr_i),
    .rd_dat_o(rd_dat_o), .rd_ack_o(rd_ack_o), .irq_frame_o(irq_frame_o), .irq_drop_o(irq_drop_o)
  );
  typedef struct { logic [31:0] w[8]; int nw; } slot_t;
  slot_t ring[$];
  logic [7:0] fb[$];
  int vectors = 0, miscompares = 0, pulses = 0, drop_events = 0, mhead = 0, mwr = 0, mdrop = 0;
  bit men = 0;
  logic pre_irq;
  initial dsp_clk = 1'b0;
  always #5 dsp_clk = ~dsp_clk;
  always @(posedge dsp_clk) if (irq_drop_o === 1'b1) pulses++;
  task automatic tick();
    @(posedge dsp_clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] crc_fb();
    logic [15:0] c = 16'd0;
    foreach (fb[i]) for (int j = 0; j < 8; j++) c = (c[0] ^ fb[i][j]) ? (c >> 1) ^ 16'h8408 : c >> 1;
    return c;
  endfunction
  task automatic rand_body(input int n, input bit fcs);
    logic [15:0] c;
    fb.delete();
    for (int i = 0; i < (fcs ? n - 2 : n); i++) fb.push_back(8'($urandom));
    if (fcs) begin
      c = crc_fb();
      fb.push_back(c[7:0]);
      fb.push_back(c[15:8]);
    end
  endtask
  task automatic model_frame(input logic [7:0] lenb, input logic [31:0] pwr);
    slot_t s;
    int st;
    logic fcs;
    if (!men) return;
    if (ring.size() == NS || lenb == 8'd0 || lenb > 8'd127) begin
      drop_events++;
      if (mdrop < 65535) mdrop++;
      return;
    end
    st = int'(lenb) > CAP ? CAP : int'(lenb);
`ifdef WIFIRE_RING_FCS_CHECK_EN
    fcs = crc_fb() == 16'd0 && int'(lenb) <= CAP;
`else
    fcs = 1'b0;
`endif
    s.w[0] = {14'd0, fcs, int'(lenb) > CAP, 8'(st), lenb};
    s.w[1] = pwr;
    for (int i = 2; i < 8; i++) s.w[i] = 32'd0;
    for (int k = 0; k < st; k++) s.w[2 + k / 4] |= 32'(fb[k]) << (8 * (k % 4));
    s.nw = 2 + (st + 3) / 4;
    ring.push_back(s);
    mwr = (mwr + 1) % NS;
  endtask
  task automatic drive_frame(input logic [7:0] lenb, input logic [31:0] pwr);
    rcv_sfd_i = 1'b1;
    rcv_power_level_i = pwr;
    tick();
    rcv_sfd_i = 1'b0;
    rcv_byte_stb_i = 1'b1;
    rcv_byte_i = lenb;
    tick();
    foreach (fb[i]) begin
      rcv_byte_i = fb[i];
      tick();
    end
    rcv_byte_stb_i = 1'b0;
  endtask
  task automatic send_frame(input logic [7:0] lenb, input logic [31:0] pwr);
    drive_frame(lenb, pwr);
    pre_irq = irq_frame_o;
    tick();
    model_frame(lenb, pwr);
  endtask
  task automatic setting(input int a, input logic [31:0] d);
    set_stb = 1'b1;
    set_addr = 8'(BASE + a);
    set_data = d;
    tick();
    set_stb = 1'b0;
    case (a)
      0: begin ring.delete(); mhead = 0; mwr = 0; end
      1: men = d[0];
      2: if (ring.size() > 0) begin ring.delete(0); mhead = (mhead + 1) % NS; end
      default: mdrop = 0;
    endcase
  endtask
  task automatic rd(input int a, output logic [31:0] d);
    rd_stb_i = 1'b1;
    rd_adr_i = 6'(a);
    tick();
    rd_stb_i = 1'b0;
    chk("rd_ack", 32'(rd_ack_o), 32'd1);
    d = rd_dat_o;
  endtask
  task automatic check_status(input string tag);
    logic [31:0] d;
    rd(32, d);
    chk(tag, d, 32'(ring.size() * 2**20 + mhead * 2**18 + mwr * 2**16 + mdrop));
    chk({tag, "_irq_frame"}, 32'(irq_frame_o), 32'(ring.size() != 0));
    chk({tag, "_drop_pulses"}, pulses, drop_events);
  endtask
  task automatic check_ring();
    logic [31:0] d;
    foreach (ring[s]) for (int i = 0; i < ring[s].nw; i++) begin
      rd(s * 8 + i, d);
      chk($sformatf("slot%0d_w%0d", s, i), d, ring[s].w[i]);
    end
  endtask
  initial begin
    logic [31:0] d;
    logic [15:0] c;
    logic [7:0] lb;
    int n, r;
    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    rcv_byte_i = '0; rcv_byte_stb_i = 1'b0; rcv_sfd_i = 1'b0; rcv_power_level_i = '0;
    rd_stb_i = 1'b0; rd_adr_i = '0;
    repeat (3) tick();
    chk("rst_irq_frame", 32'(irq_frame_o), 32'd0);
    chk("rst_irq_drop", 32'(irq_drop_o), 32'd0);
    chk("rst_rd_ack", 32'(rd_ack_o), 32'd0);
    chk("rst_rd_dat", rd_dat_o, 32'd0);
    reset = 1'b0;
    tick();
    check_status("rst_status");
    // Reference frame with known layout
    setting(1, 32'd1);
    fb = '{8'h03, 8'h08, 8'h5a, 8'hff, 8'hff, 8'hff, 8'hff};
    repeat (3) fb.push_back(8'($urandom));
    send_frame(8'd10, 32'hdeadbeef);
    chk("t1_irq_before_commit", 32'(pre_irq), 32'd0);
    chk("t1_irq_after_commit", 32'(irq_frame_o), 32'd1);
    rd(0, d); chk("t1_w0_lo", {16'd0, d[15:0]}, 32'h0a0a);
    rd(1, d); chk("t1_w1", d, 32'hdeadbeef);
    rd(2, d); chk("t1_w2", d, 32'hff5a0803);
    check_ring();
    setting(2, 32'd0);
    chk("t1_irq_released", 32'(irq_frame_o), 32'd0);
    // Fill the ring, then overflow it
    for (int i = 0; i < 4; i++) begin
      n = $urandom_range(1, 30);
      rand_body(n, n >= 3 && $urandom_range(0, 1) == 1);
      send_frame(8'(n), $urandom);
    end
    rand_body(5, 1'b0);
    send_frame(8'd5, $urandom);
    chk("t2_irq_drop_idle", 32'(irq_drop_o), 32'd0);
    check_status("t2_status");
    check_ring();
    repeat (4) setting(2, 32'd0);
    chk("t2_irq_drained", 32'(irq_frame_o), 32'd0);
    // SFD mid-body aborts without counting a drop
    rand_body(5, 1'b0);
    drive_frame(8'd20, 32'h1111_2222);
    fb = '{8'haa, 8'hbb, 8'hcc};
    send_frame(8'd3, 32'h3333_4444);
    check_status("t3_status");
    rd(0, d); chk("t3_len", {24'd0, d[7:0]}, 32'd3);
    check_ring();
    setting(2, 32'd0);
    // Illegal lengths
    rand_body(5, 1'b0);
    send_frame(8'h80, $urandom);
    check_status("t4_len80");
    send_frame(8'h00, $urandom);
    check_status("t4_len0");
    // Truncation beyond capacity
    rand_body(30, 1'b0);
    send_frame(8'd30, $urandom);
    rd(0, d); chk("t5_trunc", 32'(d[16]), 32'd1);
    chk("t5_stored", {24'd0, d[15:8]}, 32'd24);
    check_ring();
    setting(2, 32'd0);
    // FCS good and corrupted
    fb = '{8'h03, 8'h08, 8'h5a};
    c = crc_fb();
    fb.push_back(c[7:0]);
    fb.push_back(c[15:8]);
    send_frame(8'd5, 32'h55);
    rd(0, d);
`ifdef WIFIRE_RING_FCS_CHECK_EN
    chk("t6_fcs_good", 32'(d[17]), 32'd1);
`else
    chk("t6_fcs_good", 32'(d[17]), 32'd0);
`endif
    setting(2, 32'd0);
    fb[1] = fb[1] ^ 8'h10;
    send_frame(8'd5, 32'h66);
    rd(0, d); chk("t6_fcs_bad", 32'(d[17]), 32'd0);
    check_ring();
    setting(2, 32'd0);
    // Flush in the commit cycle
    fb = '{8'h11, 8'h22, 8'h33};
    drive_frame(8'd3, 32'h77);
    setting(0, 32'd0);
    chk("t7_irq_after_flush", 32'(irq_frame_o), 32'd0);
    check_status("t7_status");
    // Disabled receiver, empty release, drop clear
    setting(1, 32'd0);
    rand_body(4, 1'b0);
    send_frame(8'd4, $urandom);
    check_status("t8_disabled");
    setting(1, 32'd1);
    setting(2, 32'd0);
    check_status("t8_release_empty");
    setting(3, 32'd0);
    check_status("t8_drop_clear");
    // Reset in the middle of a frame
    send_frame(8'h90, $urandom);
    rand_body(3, 1'b0);
    drive_frame(8'd10, 32'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ring.delete(); mhead = 0; mwr = 0; mdrop = 0; men = 0;
    check_status("t9_after_reset");
    setting(1, 32'd1);
    rand_body(7, 1'b0);
    send_frame(8'd7, $urandom);
    check_status("t9_status");
    check_ring();
    // Random traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(0, 9);
      if (r < 5) begin
        n = $urandom_range(1, 36);
        rand_body(n, n >= 3 && $urandom_range(0, 1) == 1);
        lb = ($urandom_range(0, 9) == 0) ? 8'(128 + $urandom_range(0, 127)) : 8'(n);
        send_frame(lb, $urandom);
      end else if (r < 8) setting(2, 32'd0);
      else begin
        check_status("rnd_status");
        check_ring();
      end
    end
    check_status("final_status");
    check_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/wifire_frame_ring.md
Name: wifire_frame_ring

Overview:
Parametrised successor to the single-frame wifire capture block. It takes the receiver's byte stream (SFD plus byte strobes) and parses each 802.15.4 PHY frame (length byte, then MPDU). Complete frames are stored in a ring of NUM_SLOTS slots, so software can drain several frames while reception continues. It sits between the receiver byte deframer and the host register bus, is configured over the settings bus, and raises a level IRQ while complete frames are pending.

Parameters:
BASE, 16, settings-bus base address
SLOT_AW, 2, log2 of slot count (NUM_SLOTS = 2^SLOT_AW)
WORD_AW, 6, log2 of 32-bit words per slot; payload capacity is (2^WORD_AW - 2)*4 bytes
DROP_W, 16, drop-counter width (saturating)

Ports:
dsp_clk  in  1  sole clock
reset  in  1  synchronous, active-high
set_stb  in  1  settings strobe
set_addr  in  8  settings address
set_data  in  32  settings data
rcv_byte_i  in  8  received byte
rcv_byte_stb_i  in  1  byte valid, one cycle
rcv_sfd_i  in  1  start-of-frame pulse
rcv_power_level_i  in  32  power level, latched at SFD
rd_stb_i  in  1  read request
rd_adr_i  in  SLOT_AW+WORD_AW+1  read address
rd_dat_o  out  32  read data
rd_ack_o  out  1  read acknowledge
irq_frame_o  out  1  high while the ring holds at least one committed frame
irq_drop_o  out  1  one-cycle pulse per dropped frame

Behaviour:
- Reset: all outputs 0; pointers, count, drop counter and state cleared; enable = 0; slot memory contents undefined.
- Settings: BASE+0 flush (pointers, count, state; drop counter kept); BASE+1 enable = set_data[0]; BASE+2 release the head slot; BASE+3 clear the drop counter. Flush has priority over every other event in the same cycle.
- FSM IDLE/LEN/BODY/COMMIT. rcv_sfd_i has priority over a byte strobe in the same cycle.
- IDLE: on SFD with enable=1:
  - Ring full: drop, stay in IDLE.
  - Otherwise: latch power level, go to LEN.
  - Bytes received in IDLE are ignored.
- LEN: on a byte strobe, lengths 0 or >127 count as a drop and return to IDLE. Otherwise latch len[6:0] and go to BODY.
- BODY:
  - Pack bytes little-endian into words (byte k goes to word 2+k/4, bits 8*(k%4)+7:8*(k%4)).
  - Write each word when its 4th byte arrives.
  - Bytes beyond capacity are discarded and set the truncated flag.
  - After byte number len, go to COMMIT.
  - SFD in BODY aborts the frame: it is not committed and not counted as a drop, and the FSM restarts in LEN.
- COMMIT (one cycle): write any partial word (unused bytes 0), write word 0 status and word 1 power, advance wr_slot, count+1. irq_frame_o is high from the 2nd rising edge after the final byte strobe.
- Slot word 0 = {14'b0, fcs_ok[17], truncated[16], stored_bytes[15:8], len[7:0]}. Word 1 = power level.
- Release when count=0 is ignored. Commit and release in the same cycle leave count unchanged, and both pointers advance.
- Drop counter saturates at all-ones. irq_drop_o pulses in the cycle the drop is counted.
- Read address:
  - MSB=0: slot offset (relative to head: 0 = oldest) and word index.
  - MSB=1, word 0: status = {count, head index, wr index, drop counter}, zero-extended and packed LSB-first.
  - rd_ack_o and rd_dat_o are valid exactly 1 cycle after rd_stb_i; back-to-back reads are allowed.
  - Reading an offset >= count returns stale data without error.
- Reset mid-frame: frame discarded, returns to IDLE.

Optional Feature:
WIFIRE_RING_FCS_CHECK_EN:
- Defined: a CRC-16/ITU-T (poly 0x1021, init 0, LSB-first) runs over all len bytes. fcs_ok = 1 when the residual is 0 and the frame was not truncated.
- Undefined: no CRC logic, and fcs_ok always reads 0.

Test Plan:
- Enable, SFD, len=10, bytes 03 08 5a ff ff ff ff, then 3 more bytes. Expected: irq_frame_o high 2 cycles after the last byte; word0[15:0]=0x0a0a; word1=0xdeadbeef; word2=0xff5a0803.
- Commit 4 frames back-to-back, then a 5th SFD. Expected: 5th frame dropped; irq_drop_o pulses once; status count=4, drop=1. Release ×4 drops irq_frame_o to 0.
- SFD, len=20, 5 bytes, SFD, len=3, 3 bytes. Expected: exactly one frame committed, word0[7:0]=3, no drop counted.
- Length byte 0x80. Expected: drop=1, FSM back in IDLE; the following bytes are ignored and count stays 0.
- WORD_AW=3 (24-byte capacity), len=30. Expected: truncated=1, stored_bytes=24; the frame is still committed.
- FCS_EN: frame 03 08 5a with a correct 2-byte FCS gives fcs_ok=1; flipping one bit gives fcs_ok=0. Flush in the same cycle as a commit leaves count=0.
